// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] TAG_BASE = 8'hA0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TAG       = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_t;

  function automatic logic [BYTE_W-1:0] tag_byte(input logic [1:0] idx);
    return TAG_BASE + {6'd0, idx};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req searching from ptr+1 with wrap.
module rr_pick #(
  parameter int N     = 2,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             found
);

  // Walk candidates farthest-first so the nearest one after ptr overwrites the rest
  always_comb begin
    gnt   = {N{1'b0}};
    found = 1'b0;
    for (int i = N; i >= 1; i--) begin
      for (int j = 0; j < N; j++) begin
        if (req[j] && (j == ((int'(ptr) + i) % N))) begin
          gnt    = {N{1'b0}};
          gnt[j] = 1'b1;
          found  = 1'b1;
        end else begin
          gnt = gnt;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding byte streams from NUM_REQ requesters into one UART transmitter.
// Define UART_ARB_TAG_EN to prefix each packet with a tag byte (TAG_BASE + owner index).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int MAX_PKT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [NUM_REQ-1:0]        grant
);

  localparam int         PTR_W   = $clog2(NUM_REQ);
  localparam logic [7:0] MAX_CNT = 8'(MAX_PKT);

  state_t              state_r, state_s;
  logic [NUM_REQ-1:0]  grant_r, grant_s, pick_s;
  logic [PTR_W-1:0]    gidx_r, gidx_s, rr_ptr_r, rr_ptr_s, pick_idx_s;
  logic [7:0]          cnt_r, cnt_s;
  logic                last_r, last_s, tx_start_r, tx_start_s;
  logic [BYTE_W-1:0]   tx_data_r, tx_data_s, sel_byte_s;
  logic                sel_last_s, pick_found_s, accept_s;
`ifdef UART_ARB_TAG_EN
  logic                tag_r, tag_s;
`endif

  rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .gnt   (pick_s),
    .found (pick_found_s)
  );

  // Owner's byte/last select and one-hot to index conversion of the picker result
  always_comb begin
    sel_byte_s = 8'h00;
    sel_last_s = 1'b0;
    pick_idx_s = {PTR_W{1'b0}};
    for (int j = 0; j < NUM_REQ; j++) begin
      sel_byte_s = sel_byte_s | ({BYTE_W{grant_r[j]}} & req_data[j*BYTE_W +: BYTE_W]);
      sel_last_s = sel_last_s | (grant_r[j] & req_last[j]);
      pick_idx_s = pick_idx_s | ({PTR_W{pick_s[j]}} & PTR_W'(j));
    end
  end

  assign req_ready = (rst && (state_r == ST_SEND) && !tx_busy) ? (grant_r & req_valid)
                                                              : {NUM_REQ{1'b0}};
  assign accept_s  = |req_ready;

  // Next-state and next-output logic
  always_comb begin
    state_s    = state_r;
    grant_s    = grant_r;
    gidx_s     = gidx_r;
    rr_ptr_s   = rr_ptr_r;
    cnt_s      = cnt_r;
    last_s     = last_r;
    tx_start_s = 1'b0;
    tx_data_s  = tx_data_r;
`ifdef UART_ARB_TAG_EN
    tag_s      = tag_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          grant_s = pick_s;
          gidx_s  = pick_idx_s;
          cnt_s   = 8'd0;
`ifdef UART_ARB_TAG_EN
          state_s = ST_TAG;
`else
          state_s = ST_SEND;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
`ifdef UART_ARB_TAG_EN
      ST_TAG: begin
        tx_start_s = 1'b1;
        tx_data_s  = tag_byte(2'(gidx_r));
        tag_s      = 1'b1;
        state_s    = ST_WAIT_ACK;
      end
`endif
      ST_SEND: begin
        if (accept_s) begin
          tx_start_s = 1'b1;
          tx_data_s  = sel_byte_s;
          cnt_s      = cnt_r + 8'd1;
          last_s     = sel_last_s;
          state_s    = ST_WAIT_ACK;
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_WAIT_ACK: begin
        if (tx_busy) begin
          state_s = ST_WAIT_DONE;
        end else begin
          state_s = ST_WAIT_ACK;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
`ifdef UART_ARB_TAG_EN
          if (tag_r) begin
            tag_s   = 1'b0;
            state_s = ST_SEND;
          end else
`endif
          if (last_r || (cnt_r == MAX_CNT)) begin
            grant_s  = {NUM_REQ{1'b0}};
            rr_ptr_s = gidx_r;
            state_s  = ST_IDLE;
          end else begin
            state_s = ST_SEND;
          end
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end
      default: begin
        grant_s = {NUM_REQ{1'b0}};
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      grant_r    <= {NUM_REQ{1'b0}};
      gidx_r     <= {PTR_W{1'b0}};
      rr_ptr_r   <= PTR_W'(NUM_REQ - 1);
      cnt_r      <= 8'd0;
      last_r     <= 1'b0;
      tx_start_r <= 1'b0;
      tx_data_r  <= 8'h00;
`ifdef UART_ARB_TAG_EN
      tag_r      <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      grant_r    <= grant_s;
      gidx_r     <= gidx_s;
      rr_ptr_r   <= rr_ptr_s;
      cnt_r      <= cnt_s;
      last_r     <= last_s;
      tx_start_r <= tx_start_s;
      tx_data_r  <= tx_data_s;
`ifdef UART_ARB_TAG_EN
      tag_r      <= tag_s;
`endif
    end
  end

  assign grant    = grant_r;
  assign tx_start = tx_start_r;
  assign tx_data  = tx_data_r;

endmodule
